// File: rtl/life_pass_ctrl.sv
// Sequencer for a double-buffered Game-of-Life engine: runs generation passes
// that ping-pong between two memory banks and arbitrates init/video row access.
module life_pass_ctrl #(
  parameter int DEPTH  = 256,
  parameter int DBITS  = 8,
  parameter int WB_LAG = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [15:0]      gens_req,
  output logic             busy,
  output logic             done,
  output logic             cur_bank,
  input  logic             init_req,
  input  logic [DBITS-2:0] init_row,
  output logic             init_gnt,
  input  logic             vid_req,
  input  logic [DBITS-2:0] vid_row,
  output logic             vid_gnt,
  output logic             vid_valid,
  output logic [DBITS-1:0] raddr,
  output logic [DBITS-1:0] waddr,
  output logic             we,
  output logic             sh,
  output logic             ld,
  output logic             init
);

  localparam int FROWS = DEPTH / 2;
  localparam int ROWW  = DBITS - 1;
  localparam int L     = FROWS + 2 + WB_LAG;
  localparam int CW    = $clog2(L + 1);

  localparam logic [CW-1:0] C_LAST     = CW'(L - 1);
  localparam logic [CW-1:0] C_RD_END   = CW'(FROWS + 2);
  localparam logic [CW-1:0] C_WB_START = CW'(WB_LAG);
  localparam logic [CW-1:0] C_WB_END   = CW'(WB_LAG + FROWS);

  typedef enum logic [1:0] {S_IDLE, S_PASS, S_GAP} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   c_q, c_d;
  logic [15:0]     rem_q, rem_d;
  logic            bank_q, bank_d;
  logic [2:0]      vpipe_q, vpipe_d;
  logic            busy_q, busy_d, done_q, done_d;
  logic            init_gnt_q, init_gnt_d, vid_gnt_q, vid_gnt_d;
  logic            vid_valid_q, vid_valid_d;
  logic [DBITS-1:0] raddr_q, raddr_d, waddr_q, waddr_d;
  logic            we_q, we_d, sh_q, sh_d, ld_q, ld_d, init_q, init_d;
  logic [ROWW-1:0] rd_row, wb_row;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
    state_d    = state_q;
    c_d        = c_q;
    rem_d      = rem_q;
    bank_d     = bank_q;
    done_d     = 1'b0;
    init_gnt_d = 1'b0;
    vid_gnt_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (gens_req == 16'd0) begin
            done_d = 1'b1;
          end else begin
            rem_d   = gens_req;
            state_d = S_PASS;
            c_d     = '0;
          end
        // A request is still high during its own grant cycle; don't grant it twice.
        end else if (init_req && !init_gnt_q) begin
          init_gnt_d = 1'b1;
        end else if (vid_req && !vid_gnt_q) begin
          vid_gnt_d = 1'b1;
        end
      end
      S_PASS: begin
        if (c_q == C_LAST) begin
          bank_d = ~bank_q;
          rem_d  = rem_q - 16'd1;
          c_d    = '0;
          if (rem_q != 16'd1) begin
            state_d   = S_GAP;
            vid_gnt_d = vid_req;
          end else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end else begin
          c_d = c_q + CW'(1);
        end
      end
      S_GAP: begin
        state_d = S_PASS;
        c_d     = '0;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered, so they are derived from the next-cycle state.
    rd_row      = ROWW'(c_d - CW'(1));
    wb_row      = ROWW'(c_d - C_WB_START);
    busy_d      = (state_d != S_IDLE);
    sh_d        = 1'b0;
    we_d        = 1'b0;
    ld_d        = vid_gnt_d;
    init_d      = init_gnt_d;
    raddr_d     = raddr_q;
    waddr_d     = waddr_q;
    vpipe_d     = {vpipe_q[1:0], vid_gnt_q};
    vid_valid_d = vpipe_q[2];

    if (state_d == S_PASS) begin
      sh_d    = 1'b1;
      raddr_d = (c_d < C_RD_END) ? {bank_d, rd_row} : {bank_d, {ROWW{1'b0}}};
      if (c_d >= C_WB_START && c_d < C_WB_END) begin
        we_d    = 1'b1;
        waddr_d = {~bank_d, wb_row};
      end
    end
    if (vid_gnt_d) raddr_d = {bank_d, vid_row};
    if (init_gnt_d) begin
      we_d    = 1'b1;
      waddr_d = {bank_d, init_row};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      c_q         <= '0;
      rem_q       <= '0;
      bank_q      <= 1'b0;
      vpipe_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      init_gnt_q  <= 1'b0;
      vid_gnt_q   <= 1'b0;
      vid_valid_q <= 1'b0;
      raddr_q     <= '0;
      waddr_q     <= '0;
      we_q        <= 1'b0;
      sh_q        <= 1'b0;
      ld_q        <= 1'b0;
      init_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      c_q         <= c_d;
      rem_q       <= rem_d;
      bank_q      <= bank_d;
      vpipe_q     <= vpipe_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      init_gnt_q  <= init_gnt_d;
      vid_gnt_q   <= vid_gnt_d;
      vid_valid_q <= vid_valid_d;
      raddr_q     <= raddr_d;
      waddr_q     <= waddr_d;
      we_q        <= we_d;
      sh_q        <= sh_d;
      ld_q        <= ld_d;
      init_q      <= init_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign cur_bank  = bank_q;
  assign init_gnt  = init_gnt_q;
  assign vid_gnt   = vid_gnt_q;
  assign vid_valid = vid_valid_q;
  assign raddr     = raddr_q;
  assign waddr     = waddr_q;
  assign we        = we_q;
  assign sh        = sh_q;
  assign ld        = ld_q;
  assign init      = init_q;

endmodule

// File: tb/tb_life_pass_ctrl.sv
// Directed bench for life_pass_ctrl at DEPTH=16 (8 rows per bank, pass length 15).
module tb_life_pass_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] gens_req;
  logic        busy, done, cur_bank;
  logic        init_req, init_gnt;
  logic [2:0]  init_row, vid_row;
  logic        vid_req, vid_gnt, vid_valid;
  logic [3:0]  raddr, waddr;
  logic        we, sh, ld, init;

  int checks = 0;
  int failures = 0;

  life_pass_ctrl #(.DEPTH(16), .DBITS(4), .WB_LAG(5)) dut (
    .clk(clk), .reset(reset), .start(start), .gens_req(gens_req),
    .busy(busy), .done(done), .cur_bank(cur_bank),
    .init_req(init_req), .init_row(init_row), .init_gnt(init_gnt),
    .vid_req(vid_req), .vid_row(vid_row), .vid_gnt(vid_gnt), .vid_valid(vid_valid),
    .raddr(raddr), .waddr(waddr), .we(we), .sh(sh), .ld(ld), .init(init)
  );

  always #5 clk = ~clk;

  logic [17:0] outs;
  assign outs = {busy, done, cur_bank, init_gnt, vid_gnt, vid_valid,
                 raddr, waddr, we, sh, ld, init};

  // After this returns, outputs reflect the new cycle and inputs set now are sampled next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; start = 1'b0; gens_req = '0;
    init_req = 1'b0; init_row = '0; vid_req = 1'b0; vid_row = '0;
    tick(); tick();
    reset = 1'b1;
  endtask

  // Entered at pass cycle c=0; checks through c=14 without stepping past it.
  task automatic run_pass(input logic bank, output logic [14:0] vv);
    int off;
    int er;
    int ew;
    logic exp_we;
    vv = '0;
    for (int c = 0; c < 15; c++) begin
      if (c > 0) tick();
      off = (c == 0) ? 7 : ((c <= 8) ? c - 1 : 0);
      er = (bank ? 8 : 0) + off;
      exp_we = (c >= 5 && c <= 12);
      ew = (bank ? 0 : 8) + (c - 5);
      checks++;
      if (sh !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
        failures++;
        $display("FAIL pass_ctl c=%0d sh/busy/done got %b%b%b want 110", c, sh, busy, done);
      end
      checks++;
      if (raddr !== 4'(er)) begin
        failures++;
        $display("FAIL pass_raddr c=%0d got %0d want %0d", c, raddr, er);
      end
      checks++;
      if (we !== exp_we) begin
        failures++;
        $display("FAIL pass_we c=%0d got %b want %b", c, we, exp_we);
      end
      if (exp_we) begin
        checks++;
        if (waddr !== 4'(ew)) begin
          failures++;
          $display("FAIL pass_waddr c=%0d got %0d want %0d", c, waddr, ew);
        end
      end
      checks++;
      if (cur_bank !== bank || init_gnt !== 1'b0 || vid_gnt !== 1'b0 || ld !== 1'b0 || init !== 1'b0) begin
        failures++;
        $display("FAIL pass_quiet c=%0d bank/ignt/vgnt/ld/init got %b%b%b%b%b want %b0000",
                 c, cur_bank, init_gnt, vid_gnt, ld, init, bank);
      end
      vv[c] = vid_valid;
    end
  endtask

  task automatic test_reset();
    do_reset();
    reset = 1'b0;
    #1;
    checks++;
    if (outs !== '0) begin
      failures++;
      $display("FAIL reset_outs got %h want 0", outs);
    end
    reset = 1'b1;
    tick();
    checks++;
    if (outs !== '0) begin
      failures++;
      $display("FAIL idle_after_reset got %h want 0", outs);
    end
  endtask

  task automatic test_single_pass();
    logic [14:0] vv;
    start = 1'b1; gens_req = 16'd1;
    tick();
    start = 1'b0;
    run_pass(1'b0, vv);
    tick();
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || sh !== 1'b0 || we !== 1'b0) begin
      failures++;
      $display("FAIL single_end done/busy/sh/we got %b%b%b%b want 1000", done, busy, sh, we);
    end
    checks++;
    if (cur_bank !== 1'b1 || waddr !== 4'd15) begin
      failures++;
      $display("FAIL single_bank_hold bank=%b waddr=%0d want bank=1 waddr=15", cur_bank, waddr);
    end
    tick();
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL single_done_width got %b want 0", done);
    end
  endtask

  task automatic test_multi();
    logic [14:0] vv;
    logic bank;
    do_reset();
    start = 1'b1; gens_req = 16'd3;
    tick();
    start = 1'b0;
    bank = 1'b0;
    for (int p = 0; p < 3; p++) begin
      run_pass(bank, vv);
      bank = ~bank;
      tick();
      if (p < 2) begin
        checks++;
        if (sh !== 1'b0 || we !== 1'b0 || busy !== 1'b1 || done !== 1'b0 || cur_bank !== bank) begin
          failures++;
          $display("FAIL gap_%0d sh/we/busy/done/bank got %b%b%b%b%b want 0010%b",
                   p, sh, we, busy, done, cur_bank, bank);
        end
        checks++;
        if (raddr !== (bank ? 4'd0 : 4'd8)) begin
          failures++;
          $display("FAIL gap_raddr_hold_%0d got %0d want %0d", p, raddr, bank ? 0 : 8);
        end
        tick();
      end
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || cur_bank !== 1'b1) begin
      failures++;
      $display("FAIL multi_end done/busy/bank got %b%b%b want 101", done, busy, cur_bank);
    end
    tick();
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL multi_done_width got %b want 0", done);
    end
  endtask

  task automatic test_vid_gap();
    logic [14:0] vv;
    do_reset();
    start = 1'b1; gens_req = 16'd2; vid_req = 1'b1; vid_row = 3'd3;
    tick();
    start = 1'b0;
    run_pass(1'b0, vv);
    checks++;
    if (vv !== '0) begin
      failures++;
      $display("FAIL vid_valid_pass1 got %b want 0", vv);
    end
    tick();
    checks++;
    if (vid_gnt !== 1'b1 || ld !== 1'b1 || sh !== 1'b0 || raddr !== 4'd11) begin
      failures++;
      $display("FAIL vid_gap_grant gnt/ld/sh got %b%b%b raddr=%0d want 110 raddr=11",
               vid_gnt, ld, sh, raddr);
    end
    vid_req = 1'b0;
    tick();
    run_pass(1'b1, vv);
    checks++;
    if (vv !== 15'b000_0000_0000_1000) begin
      failures++;
      $display("FAIL vid_valid_timing got %b want 000000000001000", vv);
    end
    tick();
    checks++;
    if (done !== 1'b1 || cur_bank !== 1'b0 || vid_valid !== 1'b0) begin
      failures++;
      $display("FAIL vid_run_end done/bank/valid got %b%b%b want 100", done, cur_bank, vid_valid);
    end
  endtask

  task automatic test_priority();
    logic [14:0] vv;
    tick();
    start = 1'b1; gens_req = 16'd1;
    init_req = 1'b1; init_row = 3'd5; vid_req = 1'b1; vid_row = 3'd2;
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || init_gnt !== 1'b0 || vid_gnt !== 1'b0) begin
      failures++;
      $display("FAIL prio_start busy/ignt/vgnt got %b%b%b want 100", busy, init_gnt, vid_gnt);
    end
    run_pass(1'b0, vv);
    tick();
    checks++;
    if (done !== 1'b1 || init_gnt !== 1'b0 || vid_gnt !== 1'b0) begin
      failures++;
      $display("FAIL prio_done done/ignt/vgnt got %b%b%b want 100", done, init_gnt, vid_gnt);
    end
    tick();
    checks++;
    if (init_gnt !== 1'b1 || init !== 1'b1 || we !== 1'b1 || waddr !== 4'd13 || vid_gnt !== 1'b0) begin
      failures++;
      $display("FAIL prio_init ignt/init/we/vgnt got %b%b%b%b waddr=%0d want 1110 waddr=13",
               init_gnt, init, we, vid_gnt, waddr);
    end
    init_req = 1'b0;
    tick();
    checks++;
    if (vid_gnt !== 1'b1 || ld !== 1'b1 || raddr !== 4'd10 || init_gnt !== 1'b0 || we !== 1'b0) begin
      failures++;
      $display("FAIL prio_vid vgnt/ld/ignt/we got %b%b%b%b raddr=%0d want 1100 raddr=10",
               vid_gnt, ld, init_gnt, we, raddr);
    end
    vid_req = 1'b0;
    tick();
    checks++;
    if (vid_gnt !== 1'b0 || ld !== 1'b0 || init_gnt !== 1'b0) begin
      failures++;
      $display("FAIL prio_quiet vgnt/ld/ignt got %b%b%b want 000", vid_gnt, ld, init_gnt);
    end
  endtask

  task automatic test_zero_gens();
    logic seen;
    start = 1'b1; gens_req = 16'd0;
    tick();
    start = 1'b0;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || sh !== 1'b0 || we !== 1'b0) begin
      failures++;
      $display("FAIL zero_done done/busy/sh/we got %b%b%b%b want 1000", done, busy, sh, we);
    end
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (sh || we || busy || done) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL zero_quiet got activity=%b want 0", seen);
    end
  endtask

  task automatic test_reset_mid_pass();
    logic [14:0] vv;
    start = 1'b1; gens_req = 16'd1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    checks++;
    if (we !== 1'b1 || cur_bank !== 1'b1) begin
      failures++;
      $display("FAIL mid_pass_pre we/bank got %b%b want 11", we, cur_bank);
    end
    #1;
    reset = 1'b0;
    #1;
    checks++;
    if (outs !== '0) begin
      failures++;
      $display("FAIL async_reset_outs got %h want 0", outs);
    end
    tick(); tick();
    checks++;
    if (outs !== '0) begin
      failures++;
      $display("FAIL held_reset_outs got %h want 0", outs);
    end
    reset = 1'b1;
    start = 1'b1; gens_req = 16'd1;
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || cur_bank !== 1'b0 || raddr !== 4'd7) begin
      failures++;
      $display("FAIL post_reset_start busy/done/bank got %b%b%b raddr=%0d want 100 raddr=7",
               busy, done, cur_bank, raddr);
    end
    run_pass(1'b0, vv);
    tick();
    checks++;
    if (done !== 1'b1 || cur_bank !== 1'b1) begin
      failures++;
      $display("FAIL post_reset_run done/bank got %b%b want 11", done, cur_bank);
    end
  endtask

  initial begin
    test_reset();
    test_single_pass();
    test_multi();
    test_vid_gap();
    test_priority();
    test_zero_gens();
    test_reset_mid_pass();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/life_pass_ctrl.md
LIFE_PASS_CTRL -- requirements
Module: life_pass_ctrl

Interface
REQ-001 Parameters, one per line: name, default, meaning.
  DEPTH  256  engine memory depth in words; bank 0 is words 0..FROWS-1, bank 1 is words FROWS..DEPTH-1, where FROWS = DEPTH/2.
  DBITS  8  engine address width, equal to log2(DEPTH).
  WB_LAG  5  pass cycles from the first read issue to the first write-back issue.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-003 Ports, one per line: name, direction, width, meaning.
  clk  in  1  clock.
  reset  in  1  asynchronous, active-low.
  start  in  1  single-cycle pulse to run gens_req generations.
  gens_req  in  16  generation count, sampled with start.
  busy  out  1  high while a run is in progress.
  done  out  1  single-cycle pulse at the end of a run.
  cur_bank  out  1  bank holding the current generation.
  init_req  in  1  level request to write one init row; held until init_gnt.
  init_row  in  DBITS-1  row index for the init write.
  init_gnt  out  1  grant pulse for init_req.
  vid_req  in  1  level request to read one row; held until vid_gnt.
  vid_row  in  DBITS-1  row index for the video read.
  vid_gnt  out  1  grant pulse for vid_req.
  vid_valid  out  1  engine dout holds the granted row.
  raddr  out  DBITS  engine read address.
  waddr  out  DBITS  engine write address.
  we  out  1  engine write enable.
  sh  out  1  engine shift enable.
  ld  out  1  engine video load.
  init  out  1  engine init-data select.

Function
REQ-010 States: IDLE, PASS, GAP. Within PASS, a cycle counter c runs 0..L-1 with L = FROWS+2+WB_LAG.
REQ-011 IDLE priority is start > init_req > vid_req, with at most one action per cycle; a request that loses stays pending.
REQ-012 Start accepted with gens_req>0: load the remaining-generation count rem = gens_req; next cycle enters PASS with c=0 and busy=1.
REQ-013 Start accepted with gens_req=0: done=1 on the next cycle; no pass runs; busy stays 0.
REQ-014 Start while busy=1 SHALL be ignored.
REQ-015 PASS: sh=1 on every cycle. For c<FROWS+2, raddr = cur_bank*FROWS + ((c-1) mod FROWS), giving the row order FROWS-1, 0, 1, ..., FROWS-1, 0 (toroidal wrap). For c>=FROWS+2, raddr = cur_bank*FROWS.
REQ-016 PASS write-back: for WB_LAG <= c < WB_LAG+FROWS, we=1 and waddr = (!cur_bank)*FROWS + (c-WB_LAG). Otherwise we=0.
REQ-017 End of PASS (c=L-1): on the next edge cur_bank toggles and rem decrements. If the new rem>0, enter GAP; else enter IDLE with done=1 and busy=0 in that same first IDLE cycle.
REQ-018 GAP lasts one cycle with sh=0 and we=0. If vid_req is pending, grant it (REQ-020) in that cycle. Either way the next cycle enters PASS with c=0, so at most one video grant occurs per GAP.
REQ-019 init_req is granted only in IDLE. The grant cycle drives init_gnt=1, init=1, we=1 and waddr = cur_bank*FROWS + init_row.
REQ-020 vid_req is granted only in IDLE or GAP. The grant cycle drives vid_gnt=1, ld=1 and raddr = cur_bank*FROWS + vid_row. vid_valid=1 for exactly one cycle, 4 cycles after the grant cycle.
REQ-021 In PASS, init_req and vid_req SHALL never be granted.
REQ-022 Outside the driving cases above, we, sh, ld, init, init_gnt and vid_gnt SHALL be 0, and raddr and waddr SHALL hold their last value.
REQ-023 All outputs SHALL be registered.

Reset
REQ-030 While reset=0, all outputs SHALL be 0, the state SHALL be IDLE, and cur_bank, rem, c and any pending vid_valid SHALL be 0.
REQ-031 Reset asserted mid-PASS aborts immediately; no done pulse is produced, and memory contents are undefined.
REQ-032 After reset deasserts, the first start is accepted on the first clock edge.

Verification
REQ-040 Cover: DEPTH=16, WB_LAG=5, start with gens_req=1 -> 15 cycles of sh=1; raddr offsets 7,0..7,0; we=1 on c=5..12 with waddr 8..15; done 1 cycle after c=14; cur_bank=1.
REQ-041 Cover: gens_req=3 -> three passes with bank order 0->1, 1->0, 0->1; one GAP cycle between passes; a single done pulse; final cur_bank=1.
REQ-042 Cover: vid_req held through a pass -> vid_gnt only in the GAP cycle, with ld=1; vid_valid exactly 4 cycles later; no grant during PASS.
REQ-043 Cover: start, init_req and vid_req all high in the same IDLE cycle -> run starts; init_gnt only after done; then vid_gnt on the following cycle.
REQ-044 Cover: gens_req=0 -> done 1 cycle after start; sh and we never asserted.
REQ-045 Cover: reset=0 at c=6 of a pass -> all outputs 0 asynchronously; after release, the state is IDLE with cur_bank=0 and no done pulse.
